// File: rtl/matriz_loader.sv
// matriz_loader: assembles two packed row-major operand matrices (A, B) from a
// stream of signed elements and presents them to the matrix operator stage.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, sel         load request (IDLE only); sel 01=A, 10=B, 11=A then B
//   in_data, in_valid  element stream input
//   in_ready           element accepted this cycle when in_valid is high
//   matrizA, matrizB   operands; element i at [i*ELEM_W +: ELEM_W]
//   out_valid          operands complete and stable (DONE)
//   out_ready          consumer has taken the operands
//   busy               any state other than IDLE
//   count              index of the next element written in the active matrix
//   err                one-cycle pulse after a protocol error
module matriz_loader #(
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned N_ELEM = 25,
  localparam int unsigned MAT_W = ELEM_W * N_ELEM,
  localparam int unsigned CNT_W = $clog2(N_ELEM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        sel,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [MAT_W-1:0]  matrizA,
  output logic [MAT_W-1:0]  matrizB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StDone} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_ELEM - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         sel_q, sel_d;
  logic [MAT_W-1:0]   mat_a_q, mat_a_d;
  logic [MAT_W-1:0]   mat_b_q, mat_b_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      sel_q   <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sel_q   <= sel_d;
      mat_a_q <= mat_a_d;
      mat_b_q <= mat_b_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sel_d     = sel_q;
    mat_a_d   = mat_a_q;
    mat_b_d   = mat_b_q;
    err_d     = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (sel != 2'b00) begin
            sel_d   = sel;
            count_d = '0;
            state_d = sel[0] ? StLoadA : StLoadB;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StLoadA, StLoadB: begin
        in_ready = 1'b1;
        err_d    = start;
        // in_ready is unconditionally high here, so in_valid alone marks a beat.
        if (in_valid) begin
          if (state_q == StLoadA) begin
            mat_a_d[count_q*ELEM_W +: ELEM_W] = in_data;
          end else begin
            mat_b_d[count_q*ELEM_W +: ELEM_W] = in_data;
          end
          if (count_q == LastIdx) begin
            count_d = '0;
            state_d = (state_q == StLoadA && sel_q == 2'b11) ? StLoadB : StDone;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      StDone: begin
        out_valid = 1'b1;
        err_d     = start;
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign matrizA = mat_a_q;
  assign matrizB = mat_b_q;
  assign busy    = (state_q != StIdle);
  assign count   = count_q;
  assign err     = err_q;

endmodule

// File: tb/tb_matriz_loader.sv
// Self-checking bench for matriz_loader. A behavioural model keeps the expected
// contents of A and B as plain element arrays, updated from the ordered list of
// accepted elements of each load.
module tb_matriz_loader;

  typedef logic [7:0] mat_t [25];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [199:0] matrizA, matrizB;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [4:0]   count;
  logic         err;

  int total = 0;
  int bad = 0;
  mat_t ref_a, ref_b;

  always #5 clk = ~clk;

  matriz_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sel      (sel),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .matrizA  (matrizA),
    .matrizB  (matrizB),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .count    (count),
    .err      (err)
  );

  function automatic logic [199:0] pack(input mat_t m);
    logic [199:0] r;
    for (int i = 0; i < 25; i++) r[i*8 +: 8] = m[i];
    return r;
  endfunction

  // Accepted element k of a load lands in A for the first 25 when A is
  // selected, otherwise in B (offset by 25 when A came first).
  task automatic model_load(input logic [1:0] s, input logic [7:0] q[$]);
    for (int k = 0; k < q.size(); k++) begin
      if (s[0] && k < 25) ref_a[k] = q[k];
      else if (s[0]) ref_b[k-25] = q[k];
      else ref_b[k] = q[k];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 25; i++) begin
      ref_a[i] = 8'h00;
      ref_b[i] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] s);
    start = 1'b1;
    sel   = s;
    tick();
    start = 1'b0;
    sel   = 2'b00;
  endtask

  task automatic release_done();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({matrizA, matrizB} !== 400'd0 || {out_valid, in_ready, busy, err} !== 4'b0 ||
        count !== 5'd0) begin
      bad++;
      $display("FAIL reset_init: A=%h B=%h ov/ir/busy/err=%b%b%b%b count=%0d (all zero needed)",
               matrizA, matrizB, out_valid, in_ready, busy, err, count);
    end
    model_clear();
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_load();
    logic [7:0] q[$];
    do_start(2'b11);
    for (int i = 0; i < 50; i++) begin
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL full_pre_done beat %0d: out_valid=%b in_ready=%b want 0/1",
                 i, out_valid, in_ready);
      end
      in_data  = 8'(i + 1);
      in_valid = 1'b1;
      q.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    model_load(2'b11, q);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_done_flags: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    total++;
    if (matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
      bad++;
      $display("FAIL full_data: A=%h B=%h want A=%h B=%h", matrizA, matrizB,
               pack(ref_a), pack(ref_b));
    end
    release_done();
  endtask

  task automatic test_a_only_stalls();
    logic [7:0] q[$];
    int beats;
    do_start(2'b10);
    for (int i = 0; i < 25; i++) begin
      in_data = 8'h80; in_valid = 1'b1; q.push_back(8'h80); tick();
    end
    in_valid = 1'b0;
    model_load(2'b10, q);
    release_done();
    q.delete();
    do_start(2'b01);
    beats = 0;
    for (int c = 0; c < 100 && beats < 25; c++) begin
      in_valid = (c % 3 != 2);
      in_data  = in_valid ? 8'hFF : 8'(c);
      if (in_valid) begin
        q.push_back(8'hFF);
        beats++;
      end
      tick();
      total++;
      if (count !== 5'((beats == 25) ? 0 : beats)) begin
        bad++;
        $display("FAIL stall_count cycle %0d: count=%0d want %0d", c, count,
                 (beats == 25) ? 0 : beats);
      end
    end
    in_valid = 1'b0;
    model_load(2'b01, q);
    total++;
    if (out_valid !== 1'b1 || matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
      bad++;
      $display("FAIL stall_data: ov=%b A=%h B=%h want ov=1 A=%h B=%h", out_valid, matrizA,
               matrizB, pack(ref_a), pack(ref_b));
    end
  endtask

  // Entered in DONE from the previous test.
  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
      total++;
      if (out_valid !== 1'b1 || matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
        bad++;
        $display("FAIL backpressure cycle %0d: ov=%b A=%h B=%h", i, out_valid, matrizA, matrizB);
      end
    end
    in_valid = 1'b0;
    // start on the accepting cycle is an error, not a new load
    start = 1'b1; sel = 2'b11;
    release_done();
    start = 1'b0; sel = 2'b00;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: busy=%b ov=%b err=%b want 0/0/1", busy, out_valid, err);
    end
    tick();
  endtask

  task automatic test_protocol_errors();
    logic [7:0] q[$];
    do_start(2'b00);
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL err_sel00: err=%b busy=%b want 1/0", err, busy);
    end
    tick();
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_one_cycle: err=%b want 0", err);
    end
    do_start(2'b10);
    for (int i = 0; i < 7; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1; q.push_back(in_data); tick();
    end
    in_valid = 1'b0;
    start = 1'b1; sel = 2'b01;
    tick();
    start = 1'b0; sel = 2'b00;
    total++;
    if (err !== 1'b1 || count !== 5'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL err_in_load: err=%b count=%0d busy=%b want 1/7/1", err, count, busy);
    end
    in_data = 8'($urandom); in_valid = 1'b1; q.push_back(in_data); tick();
    total++;
    if (count !== 5'd8 || err !== 1'b0) begin
      bad++;
      $display("FAIL err_count_cont: count=%0d err=%b want 8/0", count, err);
    end
    for (int i = 8; i < 25; i++) begin
      in_data = 8'($urandom); q.push_back(in_data); tick();
    end
    in_valid = 1'b0;
    model_load(2'b10, q);
    total++;
    if (out_valid !== 1'b1 || matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
      bad++;
      $display("FAIL err_load_data: ov=%b A=%h B=%h", out_valid, matrizA, matrizB);
    end
    release_done();
  endtask

  task automatic test_reset_mid();
    logic [7:0] q[$];
    do_start(2'b11);
    for (int i = 0; i < 12; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1; tick();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({matrizA, matrizB} !== 400'd0 || {out_valid, in_ready, busy} !== 3'b0 ||
        count !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid: A=%h B=%h ov/ir/busy=%b%b%b count=%0d want zeros",
               matrizA, matrizB, out_valid, in_ready, busy, count);
    end
    model_clear();
    #3 rst_n = 1'b1;
    tick();
    do_start(2'b01);
    for (int i = 0; i < 25; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1; q.push_back(in_data); tick();
    end
    in_valid = 1'b0;
    model_load(2'b01, q);
    total++;
    if (out_valid !== 1'b1 || matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
      bad++;
      $display("FAIL reset_reload: ov=%b A=%h B=%h want ov=1 A=%h B=%h", out_valid, matrizA,
               matrizB, pack(ref_a), pack(ref_b));
    end
    release_done();
  endtask

  task automatic test_random_loads();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] q[$];
      logic [1:0] s;
      int need;
      int cyc;
      s    = 2'($urandom_range(1, 3));
      need = (s == 2'b11) ? 50 : 25;
      do_start(s);
      cyc = 0;
      while (q.size() < need && cyc < 400) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        if (in_valid) q.push_back(in_data);
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      model_load(s, q);
      total++;
      if (out_valid !== 1'b1 || matrizA !== pack(ref_a) || matrizB !== pack(ref_b)) begin
        bad++;
        $display("FAIL random_load %0d sel=%b: ov=%b A=%h B=%h want A=%h B=%h", n, s,
                 out_valid, matrizA, matrizB, pack(ref_a), pack(ref_b));
      end
      release_done();
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_a_only_stalls();
    test_backpressure();
    test_protocol_errors();
    test_reset_mid();
    test_random_loads();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
